// File: rtl/vga_vram_arbiter.sv
// -----------------------------------------------------------------------------
// vga_vram_arbiter
//
// Shares one single-port, synchronous-read pixel RAM between the VGA scan-out
// reader and a pixel writer. Display reads always win the RAM port, so
// scan-out never stalls. Writes are posted into a small FIFO and drained one
// per cycle whenever the display is not requesting, typically during blanking.
//
// A display read of an address that still has a write pending in the FIFO
// returns the old RAM contents. No forwarding is done.
//
// Ports:
//   i_Clk        pixel clock
//   i_Reset      synchronous, active-high reset
//   i_Disp_Req   display read request this cycle
//   i_Disp_Addr  display read address
//   o_Disp_Valid o_Disp_Data holds the result of the request two cycles ago
//   o_Disp_Data  read data, combinational pass-through of i_Ram_RData
//   i_Wr_Valid   writer presents a word
//   i_Wr_Addr    write address
//   i_Wr_Data    write data
//   o_Wr_Ready   FIFO can accept a word (count < BUF_DEPTH)
//   o_Ram_Addr   registered RAM address
//   o_Ram_We     registered RAM write enable
//   o_Ram_WData  registered RAM write data
//   i_Ram_RData  RAM read data, valid one cycle after the address
//   o_Busy       registered: FIFO non-empty or a write is on the RAM port
// -----------------------------------------------------------------------------
module vga_vram_arbiter #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 3,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset,
   input  logic                  i_Disp_Req,
   input  logic [ADDR_WIDTH-1:0] i_Disp_Addr,
   output logic                  o_Disp_Valid,
   output logic [DATA_WIDTH-1:0] o_Disp_Data,
   input  logic                  i_Wr_Valid,
   input  logic [ADDR_WIDTH-1:0] i_Wr_Addr,
   input  logic [DATA_WIDTH-1:0] i_Wr_Data,
   output logic                  o_Wr_Ready,
   output logic [ADDR_WIDTH-1:0] o_Ram_Addr,
   output logic                  o_Ram_We,
   output logic [DATA_WIDTH-1:0] o_Ram_WData,
   input  logic [DATA_WIDTH-1:0] i_Ram_RData,
   output logic                  o_Busy
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

   typedef enum logic [1:0] {
      GRANT_IDLE,
      GRANT_DISP,
      GRANT_WRITE
   } grant_e;

   // Write FIFO storage and bookkeeping
   logic [ADDR_WIDTH-1:0] buf_addr_q [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] buf_data_q [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   // Grant state and registered RAM port
   grant_e                grant_q, grant_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

   // Display valid pipeline: stage 1 lines up with the RAM address register,
   // stage 2 with the RAM read data.
   logic                  disp_p1_q;
   logic                  disp_valid_q;

   logic                  busy_q, busy_d;
   logic                  push;
   logic                  pop;

   // Ready comes from the registered count only, so a pop in this cycle
   // cannot make room for a push in the same cycle.
   assign o_Wr_Ready   = (count_q < FULL_CNT);
   assign push         = i_Wr_Valid && o_Wr_Ready;

   assign o_Ram_Addr   = ram_addr_q;
   assign o_Ram_WData  = ram_wdata_q;
   assign o_Ram_We     = (grant_q == GRANT_WRITE);
   assign o_Disp_Valid = disp_valid_q;
   assign o_Disp_Data  = i_Ram_RData;
   assign o_Busy       = busy_q;

   // --------------------------------------------------------------------------
   // Grant decision: re-evaluated every cycle, display first, then FIFO drain.
   // --------------------------------------------------------------------------
   always_comb begin
      grant_d = GRANT_IDLE;
      if (i_Disp_Req) begin
         grant_d = GRANT_DISP;
      end else if (count_q != '0) begin
         grant_d = GRANT_WRITE;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state datapath: RAM port registers, FIFO pointers and count.
   // --------------------------------------------------------------------------
   always_comb begin
      pop         = (grant_d == GRANT_WRITE);
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;

      unique case (grant_d)
         GRANT_DISP: begin
            ram_addr_d = i_Disp_Addr;
         end
         GRANT_WRITE: begin
            ram_addr_d  = buf_addr_q[rd_ptr_q];
            ram_wdata_d = buf_data_q[rd_ptr_q];
         end
         default: begin
         end
      endcase

      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Busy reflects the state after this edge: entries left, or a write
      // about to be on the RAM port.
      busy_d = (count_d != '0) || pop;
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         grant_q      <= GRANT_IDLE;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         disp_p1_q    <= 1'b0;
         disp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         grant_q      <= grant_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         disp_p1_q    <= i_Disp_Req;
         disp_valid_q <= disp_p1_q;
         busy_q       <= busy_d;
      end
   end

   // FIFO payload needs no reset: entries are only read when count says so.
   always_ff @(posedge i_Clk) begin
      if (!i_Reset && push) begin
         buf_addr_q[wr_ptr_q] <= i_Wr_Addr;
         buf_data_q[wr_ptr_q] <= i_Wr_Data;
      end
   end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_vram_arbiter
//
// Drives vga_vram_arbiter with directed and randomized display/writer traffic,
// attaches a behavioural single-port synchronous-read RAM, and compares every
// cycle against a queue-based model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_vga_vram_arbiter;

   localparam int AW    = 13;
   localparam int DW    = 3;
   localparam int DEPTH = 4;
   localparam int MEMSZ = 1 << AW;

   logic          clk;
   logic          rst;
   logic          req;
   logic [AW-1:0] daddr;
   logic          wv;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;

   logic          o_Disp_Valid;
   logic [DW-1:0] o_Disp_Data;
   logic          o_Wr_Ready;
   logic [AW-1:0] o_Ram_Addr;
   logic          o_Ram_We;
   logic [DW-1:0] o_Ram_WData;
   logic [DW-1:0] ram_rdata;
   logic          o_Busy;

   vga_vram_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .BUF_DEPTH  (DEPTH)
   ) dut (
      .i_Clk        (clk),
      .i_Reset      (rst),
      .i_Disp_Req   (req),
      .i_Disp_Addr  (daddr),
      .o_Disp_Valid (o_Disp_Valid),
      .o_Disp_Data  (o_Disp_Data),
      .i_Wr_Valid   (wv),
      .i_Wr_Addr    (waddr),
      .i_Wr_Data    (wdata),
      .o_Wr_Ready   (o_Wr_Ready),
      .o_Ram_Addr   (o_Ram_Addr),
      .o_Ram_We     (o_Ram_We),
      .o_Ram_WData  (o_Ram_WData),
      .i_Ram_RData  (ram_rdata),
      .o_Busy       (o_Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pixel RAM attached to the DUT: synchronous read, read-old on write.
   logic [DW-1:0] ram [MEMSZ];
   always @(posedge clk) begin
      if (o_Ram_We) ram[o_Ram_Addr] <= o_Ram_WData;
      ram_rdata <= ram[o_Ram_Addr];
   end

   // ---------------------------------------------------------------------------
   // Reference model: pending-write queue, expected RAM image, expected outputs.
   // ---------------------------------------------------------------------------
   logic [DW-1:0] mem_model [MEMSZ];
   int            mq_addr[$];
   int            mq_data[$];
   logic          m_we, m_busy, m_acc;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_v1, m_v2;
   logic [DW-1:0] m_d1, m_d2;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Advances the model across one clock edge using the inputs now applied.
   task automatic model_step();
      logic do_wr;
      if (rst) begin
         mq_addr.delete();
         mq_data.delete();
         m_we    = 1'b0;
         m_addr  = '0;
         m_wdata = '0;
         m_v1    = 1'b0;
         m_v2    = 1'b0;
         m_busy  = 1'b0;
         m_acc   = 1'b0;
         return;
      end
      m_acc = wv && (mq_addr.size() < DEPTH);
      do_wr = !req && (mq_addr.size() > 0);
      m_v2  = m_v1;
      m_d2  = m_d1;
      m_v1  = req;
      // Pending writes are invisible to reads; only issued writes count.
      m_d1  = mem_model[daddr];
      m_we  = do_wr;
      if (req) begin
         m_addr = daddr;
      end else if (do_wr) begin
         m_addr  = AW'(mq_addr.pop_front());
         m_wdata = DW'(mq_data.pop_front());
         mem_model[m_addr] = m_wdata;
      end
      if (m_acc) begin
         mq_addr.push_back(int'(waddr));
         mq_data.push_back(int'(wdata));
      end
      m_busy = (mq_addr.size() > 0) || m_we;
   endtask

   task automatic compare();
      chk("ram_we",    32'(o_Ram_We),     32'(m_we));
      chk("ram_addr",  32'(o_Ram_Addr),   32'(m_addr));
      chk("ram_wdata", 32'(o_Ram_WData),  32'(m_wdata));
      chk("disp_valid",32'(o_Disp_Valid), 32'(m_v2));
      if (m_v2) chk("disp_data", 32'(o_Disp_Data), 32'(m_d2));
      chk("wr_ready",  32'(o_Wr_Ready),   32'(mq_addr.size() < DEPTH));
      chk("busy",      32'(o_Busy),       32'(m_busy));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      if (m_acc) wv = 1'b0;
      compare();
   endtask

   // Presents a new word unless the writer is still holding one.
   task automatic offer(input int a, input int d);
      if (!wv) begin
         wv    = 1'b1;
         waddr = AW'(a);
         wdata = DW'(d);
      end
   endtask

   initial begin
      int n;
      for (int i = 0; i < MEMSZ; i++) begin
         ram[i]       = DW'(i * 3 + 1);
         mem_model[i] = DW'(i * 3 + 1);
      end
      m_d1 = '0;
      m_d2 = '0;
      rst = 1'b1; req = 1'b0; daddr = '0; wv = 1'b0; waddr = '0; wdata = '0;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;

      // Display priority: 100 back-to-back reads while 3 writes are posted.
      for (int i = 0; i < 100; i++) begin
         req   = 1'b1;
         daddr = AW'(i);
         if (i < 3) offer(200 + i, $urandom_range(0, 7));
         tick();
      end
      req = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("drained_busy", 32'(o_Busy), 32'd0);

      // Full buffer: five pushes with display busy, then drain.
      n = 0;
      for (int c = 0; c < 16; c++) begin
         req   = (c < 8);
         daddr = AW'($urandom_range(0, 127));
         if (!wv && n < 5) begin
            offer(300 + n, $urandom_range(0, 7));
            n++;
         end
         tick();
      end

      // Ordering and last-write-wins on the same address.
      req = 1'b0;
      offer(10, 1); tick();
      offer(10, 5); tick();
      offer(11, 2); tick();
      for (int i = 0; i < 4; i++) tick();
      req = 1'b1; daddr = AW'(10); tick();
      req = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("ram10", 32'(ram[10]), 32'd5);
      chk("ram11", 32'(ram[11]), 32'd2);

      // Blanking drain: 16 display cycles, 4 idle, writer every 5 cycles.
      for (int c = 0; c < 2000; c++) begin
         req   = ((c % 20) < 16);
         daddr = AW'($urandom_range(0, 63));
         if ((c % 5) == 0) offer($urandom_range(0, 63), $urandom_range(0, 7));
         tick();
      end

      // Reset during traffic: buffered words are discarded.
      req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         daddr = AW'(i);
         offer(40 + i, 7 - int'(mem_model[40 + i]));
         tick();
      end
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      wv  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         daddr = AW'(40 + i);
         tick();
      end
      req = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      // Fully random traffic with occasional resets.
      for (int c = 0; c < 1500; c++) begin
         rst   = ($urandom_range(0, 199) == 0);
         req   = ($urandom_range(0, 2) != 0);
         daddr = AW'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1) offer($urandom_range(0, 31), $urandom_range(0, 7));
         tick();
      end
      rst = 1'b0;
      req = 1'b0;
      wv  = 1'b0;
      for (int i = 0; i < 10; i++) tick();

      // No lost or misplaced writes in the touched address range.
      for (int i = 0; i < 320; i++) chk("final_mem", 32'(ram[i]), 32'(mem_model[i]));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
